button_pulse_gen: RTL

Front-end conditioner that turns the three raw board push-buttons into the clean single-cycle `left`, `right` and `confirm` command pulses consumed by the tic-tac-toe game core. Each raw input is synchronised and debounced, then edge-detected. Left and right add hold-to-repeat for cursor scrolling. At most one command pulse leaves the block per clock, so the core never sees two commands in the same cycle.

---
 rtl/button_pulse_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/button_pulse_gen.sv
// Button front end: two-flop synchroniser, debouncer and edge detector per
// push-button, hold-to-repeat for left/right, and a priority arbiter that
// issues at most one registered command pulse per clock.
module button_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 10,
    parameter int unsigned REPEAT_RATE     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       btn_confirm_raw,
    output logic       left,
    output logic       right,
    output logic       confirm,
    output logic [2:0] held
);

    localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] RD_LAST = 24'(REPEAT_DELAY - 1);
    localparam logic [23:0] RR_LAST = 24'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    typedef enum logic {
        CF_IDLE = 1'b0,
        CF_HELD = 1'b1
    } cf_state_e;

    // Bit order everywhere: [2] confirm, [1] right, [0] left.
    logic [2:0] raw;
    logic [2:0] deb;     // debounced levels
    logic [2:0] rise;    // one-cycle flag: debounced level rose on the last edge
    logic [2:0] ev;      // command events raised by the per-button FSMs
    logic [2:0] pend_q, pend_d;
    logic [2:0] out_q, out_d;

    assign raw = {btn_confirm_raw, btn_right_raw, btn_left_raw};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_db
            logic        sync1_q, sync2_q;
            logic        deb_q, deb_d;
            logic        rise_q, rise_d;
            logic [23:0] dc_q, dc_d;

            // Debounce: flip the level only after DEBOUNCE_CYCLES disagreeing samples in a row
            always_comb begin
                deb_d  = deb_q;
                dc_d   = dc_q;
                rise_d = 1'b0;
                if (sync2_q == deb_q) begin
                    dc_d = '0;
                end else if (dc_q == DB_LAST) begin
                    deb_d  = ~deb_q;
                    dc_d   = '0;
                    rise_d = ~deb_q;
                end else begin
                    dc_d = dc_q + 24'd1;
                end
            end

            // Synchroniser, debounced level, counter and rise flag registers
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    rise_q  <= 1'b0;
                    dc_q    <= '0;
                end else begin
                    sync1_q <= raw[gi];
                    sync2_q <= sync1_q;
                    deb_q   <= deb_d;
                    rise_q  <= rise_d;
                    dc_q    <= dc_d;
                end
            end

            assign deb[gi]  = deb_q;
            assign rise[gi] = rise_q;
        end

        for (genvar gi = 0; gi < 2; gi++) begin : g_rep
            rep_state_e  state_q, state_d;
            logic [23:0] rc_q, rc_d;
            logic        ev_c;

            // Hold-to-repeat: press event, then REPEAT_DELAY, then every REPEAT_RATE
            always_comb begin
                state_d = state_q;
                rc_d    = rc_q;
                ev_c    = 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise[gi]) begin
                            ev_c    = 1'b1;
                            state_d = ST_DELAY;
                            rc_d    = '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!deb[gi]) begin
                            state_d = ST_IDLE;
                            rc_d    = '0;
                        end else if (rc_q == RD_LAST) begin
                            ev_c    = 1'b1;
                            state_d = ST_REPEAT;
                            rc_d    = '0;
                        end else begin
                            rc_d = rc_q + 24'd1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!deb[gi]) begin
                            state_d = ST_IDLE;
                            rc_d    = '0;
                        end else if (rc_q == RR_LAST) begin
                            ev_c = 1'b1;
                            rc_d = '0;
                        end else begin
                            rc_d = rc_q + 24'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rc_d    = '0;
                    end
                endcase
            end

            // Repeat FSM state and counter registers
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_IDLE;
                    rc_q    <= '0;
                end else begin
                    state_q <= state_d;
                    rc_q    <= rc_d;
                end
            end

            assign ev[gi] = ev_c;
        end
    endgenerate

    cf_state_e cf_state_q, cf_state_d;
    logic      cf_ev;

    // Confirm: one event per press, nothing while held
    always_comb begin
        cf_state_d = cf_state_q;
        cf_ev      = 1'b0;
        if (cf_state_q == CF_IDLE) begin
            if (rise[2]) begin
                cf_ev      = 1'b1;
                cf_state_d = CF_HELD;
            end
        end else if (!deb[2]) begin
            cf_state_d = CF_IDLE;
        end
    end

    // Confirm FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cf_state_q <= CF_IDLE;
        end else begin
            cf_state_q <= cf_state_d;
        end
    end

    assign ev[2] = cf_ev;

    // Arbiter: grant the highest-priority request; losers stay pending, duplicates merge
    always_comb begin
        logic [2:0] req;
        req   = pend_q | ev;
        out_d = 3'b000;
        if (req[0]) begin
            out_d = 3'b001;
        end else if (req[1]) begin
            out_d = 3'b010;
        end else if (req[2]) begin
            out_d = 3'b100;
        end
        pend_d = req & ~out_d;
    end

    // Pending flags and registered one-hot command outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 3'b000;
            out_q  <= 3'b000;
        end else begin
            pend_q <= pend_d;
            out_q  <= out_d;
        end
    end

    assign left    = out_q[0];
    assign right   = out_q[1];
    assign confirm = out_q[2];
    assign held    = deb;

endmodule
